ifetch_ctrl: RTL

//  Instruction-fetch controller; drives the PC register's next-value input (pcin).
//  - Consumes pcout; returns pc_next, which the PC register loads every clk edge (PC has no enable).
//  - Issues a req/ack read to instruction memory.
//  - Presents the fetched word to decode with a valid/ready handshake.
//  - Applies branch/jump redirects.

---
 rtl/ifetch_ctrl_if.sv | 22 ++
 rtl/ifetch_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory req/ack port and the decode valid/ready port.
// master = fetch controller, slave = memory/decode side.
interface ifetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_ack, imem_rdata, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_ack, imem_rdata, instr_ready
   );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: drives the PC register input, runs a single-outstanding
// imem read and hands words to decode. Define IFETCH_ALIGN_CHECK_EN for the misaligned-fetch FAULT state.
//
// state | meaning
// IDLE  | first cycle out of reset, no request
// REQ   | request at pc outstanding
// HOLD  | fetched word presented to decode
// DROP  | redirected while a request was in flight; wait out its ack at the old address
// FAULT | misaligned pc seen, wait for redirect (IFETCH_ALIGN_CHECK_EN only)
module ifetch_ctrl #(
   parameter logic [31:0] PC_INC = 32'd4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   i_pc,
   output logic [31:0]   o_pc_next,
   input  logic          i_redirect,
   input  logic [31:0]   i_redirect_target,
   output logic          o_fault,
   ifetch_ctrl_if.master bus
);

`ifdef IFETCH_ALIGN_CHECK_EN
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_HOLD, S_DROP, S_FAULT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;
`endif

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;
   logic [31:0] r_req_addr;
   logic [31:0] w_pc_next;
   logic [31:0] w_addr;
   logic        w_req;
   logic        w_capture;
   logic        w_misaligned;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign w_misaligned = (i_pc[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_instr    <= 32'd0;
         r_instr_pc <= 32'd0;
         r_req_addr <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_REQ) begin
            r_req_addr <= i_pc;
         end
         if (w_capture) begin
            r_instr    <= bus.imem_rdata;
            r_instr_pc <= i_pc;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_next   = i_pc;
      w_addr      = i_pc;
      w_req       = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (w_misaligned) begin
`ifdef IFETCH_ALIGN_CHECK_EN
               w_state_nxt = S_FAULT;
`endif
            end else begin
               w_req = 1'b1;
               if (bus.imem_ack && !i_redirect) begin
                  w_capture   = 1'b1;
                  w_pc_next   = i_pc + PC_INC;
                  w_state_nxt = S_HOLD;
               end else if (i_redirect) begin
                  // an ack in the same cycle retires the request, so no DROP needed
                  w_pc_next = i_redirect_target;
                  if (!bus.imem_ack) begin
                     w_state_nxt = S_DROP;
                  end
               end
            end
         end
         S_HOLD: begin
            if (i_redirect) begin
               w_pc_next   = i_redirect_target;
               w_state_nxt = S_REQ;
            end else if (bus.instr_ready) begin
               w_state_nxt = S_REQ;
            end
         end
         S_DROP: begin
            w_req  = 1'b1;
            w_addr = r_req_addr;
            if (i_redirect) begin
               w_pc_next = i_redirect_target;
            end
            if (bus.imem_ack) begin
               w_state_nxt = S_REQ;
            end
         end
`ifdef IFETCH_ALIGN_CHECK_EN
         S_FAULT: begin
            if (i_redirect) begin
               w_pc_next   = i_redirect_target;
               w_state_nxt = S_REQ;
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // reset wins over anything the current state would do this cycle
      if (reset) begin
         w_req     = 1'b0;
         w_capture = 1'b0;
         w_pc_next = i_pc;
      end
   end

   assign o_pc_next       = w_pc_next;
   assign bus.imem_req    = w_req;
   assign bus.imem_addr   = w_addr;
   assign bus.instr_valid = (r_state == S_HOLD);
   assign bus.instr       = r_instr;
   assign bus.instr_pc    = r_instr_pc;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign o_fault = (r_state == S_FAULT);
`else
   assign o_fault = 1'b0;
`endif

endmodule
